gray_count_monitor: RTL and testbench

//  Consumer end of the 16-bit Gray counter: samples a Gray-coded count, decodes it to binary,
//  and checks that each new value is a legal step (hold or +1, modulo 2^WIDTH).

---
 rtl/gray_mon_pkg.sv | 23 ++
 rtl/gray_sync_pipe.sv | 29 ++
 rtl/gray_count_monitor.sv | 112 +++++++++++
 tb/tb_gray_count_monitor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_mon_pkg.sv
// Shared types and helpers for the Gray count monitor.
// The gray2bin function works on a 64-bit word; narrower codes are zero-extended, which leaves the decode unchanged.
package gray_mon_pkg;

    localparam int GRAY_MAX_W = 64;
    localparam int DELTA_STEP = 1;

    typedef enum logic {
        ST_ACQ,
        ST_TRACK
    } state_t;

    // Zero bits above the real MSB contribute nothing to the running XOR.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync_pipe.sv
// STAGES-deep register chain that brings the observed Gray word into the clk domain.
module gray_sync_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[STAGES-1];

endmodule

// File: rtl/gray_count_monitor.sv
// Decodes a synchronised Gray count and flags any step other than hold or +1.
// Define GRAY_MON_BIDIR_EN to also accept -1 steps (down-counting sources).
module gray_count_monitor
    import gray_mon_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt
);

    logic [WIDTH-1:0] sync_gray;
    logic [WIDTH-1:0] dec_bin;
    logic [WIDTH-1:0] delta;
    logic             legal;
    logic             load;
    logic             valid_next;
    logic             err_next;
    state_t           state;
    state_t           state_next;

    gray_sync_pipe #(
        .WIDTH (WIDTH),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rstn(rstn),
        .din (gray_in),
        .dout(sync_gray)
    );

    assign dec_bin = WIDTH'(gray2bin(GRAY_MAX_W'(sync_gray)));
    assign delta   = dec_bin - bin_out;

    always_comb begin
        legal = (delta == '0) || (delta == WIDTH'(DELTA_STEP));
`ifdef GRAY_MON_BIDIR_EN
        legal = legal || (delta == '1);
`else
        legal = legal;
`endif
    end

    // ACQ takes one sample as the reference; only TRACK compares against it.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        valid_next = 1'b0;
        err_next   = 1'b0;
        if (en) begin
            load       = 1'b1;
            state_next = ST_TRACK;
            if (state == ST_TRACK) begin
                valid_next = 1'b1;
                err_next   = !legal;
            end
        end else begin
            state_next = ST_ACQ;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_ACQ;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            if (load) begin
                bin_out <= dec_bin;
            end
            bin_valid <= valid_next;
            step_err  <= err_next;
        end
    end

    // A new error outranks a concurrent clear: the clear happens first, then the error counts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (err_next) begin
            err_sticky <= 1'b1;
            if (clr_err) begin
                err_cnt <= ERR_W'(1);
            end else if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end else if (clr_err) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_count_monitor.sv
// Directed bench for gray_count_monitor: a per-cycle vector table plus counting, reset and saturation sequences.
module tb_gray_count_monitor;

    typedef struct {
        logic [15:0] gray;
        logic        en;
        logic        clr;
        logic [15:0] bin;
        logic        valid;
        logic        err;
        logic [15:0] cnt;
        logic        sticky;
    } vec_t;

`ifdef GRAY_MON_BIDIR_EN
    localparam logic        WRAP_DOWN_ERR = 1'b0;
    localparam logic [15:0] CNT_MID       = 16'd1;
`else
    localparam logic        WRAP_DOWN_ERR = 1'b1;
    localparam logic [15:0] CNT_MID       = 16'd2;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [15:0] gray_in;
    logic        clr_err;
    logic [15:0] bin_out;
    logic        bin_valid;
    logic        step_err;
    logic        err_sticky;
    logic [15:0] err_cnt;

    logic        sat_en;
    logic [15:0] sat_gray;
    logic [15:0] sat_bin;
    logic        sat_valid;
    logic        sat_err;
    logic        sat_sticky;
    logic [2:0]  sat_cnt;

    int checks = 0;
    int fails  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    gray_count_monitor dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .gray_in   (gray_in),
        .clr_err   (clr_err),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .step_err  (step_err),
        .err_sticky(err_sticky),
        .err_cnt   (err_cnt)
    );

    gray_count_monitor #(.ERR_W(3)) dut_sat (
        .clk       (clk),
        .rstn      (rstn),
        .en        (sat_en),
        .gray_in   (sat_gray),
        .clr_err   (1'b0),
        .bin_out   (sat_bin),
        .bin_valid (sat_valid),
        .step_err  (sat_err),
        .err_sticky(sat_sticky),
        .err_cnt   (sat_cnt)
    );

    function automatic logic [15:0] bin2gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic void add_vec(input logic [15:0] g, input logic e, input logic c,
                                    input logic [15:0] b, input logic v, input logic er,
                                    input logic [15:0] n, input logic s);
        vec_t r;
        r.gray = g; r.en = e; r.clr = c;
        r.bin = b; r.valid = v; r.err = er; r.cnt = n; r.sticky = s;
        vecs.push_back(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [15:0] g, input logic e, input logic c);
        gray_in = g;
        en      = e;
        clr_err = c;
        tick();
    endtask

    task automatic check_output(input string name, input logic [15:0] b, input logic v,
                                input logic er, input logic [15:0] n, input logic s);
        checks++;
        if ({bin_out, bin_valid, step_err, err_cnt, err_sticky} !== {b, v, er, n, s}) begin
            fails++;
            $display("[TB] FAIL %s: got bin=%h valid=%b err=%b cnt=%0d sticky=%b, expected bin=%h valid=%b err=%b cnt=%0d sticky=%b",
                     name, bin_out, bin_valid, step_err, err_cnt, err_sticky, b, v, er, n, s);
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; gray_in = '0; clr_err = 1'b0;
        sat_en = 1'b0; sat_gray = '0;
        #2;
        check_output("reset", 16'h0000, 1'b0, 1'b0, 16'd0, 1'b0);
        tick(); tick();
        rstn = 1'b1;
        tick(); tick();
        check_output("idle_after_reset", 16'h0000, 1'b0, 1'b0, 16'd0, 1'b0);

        // Counting source: output trails the input by three edges.
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(bin2gray(16'(i)), 1'b1, 1'b0);
            check_output($sformatf("count_%0d", i), (i < 2) ? 16'h0000 : 16'(i - 2),
                         (i >= 1), 1'b0, 16'd0, 1'b0);
        end

        // Hold at bin 2 after a re-acquire.
        add_vec(16'h0003, 0, 0, 16'h0025, 0, 0, 16'd0, 0);
        add_vec(16'h0003, 0, 0, 16'h0025, 0, 0, 16'd0, 0);
        add_vec(16'h0003, 1, 0, 16'h0002, 0, 0, 16'd0, 0);
        for (int i = 0; i < 10; i++) add_vec(16'h0003, 1, 0, 16'h0002, 1, 0, 16'd0, 0);
        // Jump bin 1 -> bin 4.
        add_vec(16'h0001, 0, 0, 16'h0002, 0, 0, 16'd0, 0);
        add_vec(16'h0001, 0, 0, 16'h0002, 0, 0, 16'd0, 0);
        add_vec(16'h0001, 1, 0, 16'h0001, 0, 0, 16'd0, 0);
        add_vec(16'h0001, 1, 0, 16'h0001, 1, 0, 16'd0, 0);
        add_vec(16'h0006, 1, 0, 16'h0001, 1, 0, 16'd0, 0);
        add_vec(16'h0006, 1, 0, 16'h0001, 1, 0, 16'd0, 0);
        add_vec(16'h0006, 1, 0, 16'h0004, 1, 1, 16'd1, 1);
        add_vec(16'h0006, 1, 0, 16'h0004, 1, 0, 16'd1, 1);
        // FFFF -> 0 wrap, then 0 -> FFFF.
        add_vec(16'h8000, 0, 0, 16'h0004, 0, 0, 16'd1, 1);
        add_vec(16'h8000, 0, 0, 16'h0004, 0, 0, 16'd1, 1);
        add_vec(16'h8000, 1, 0, 16'hFFFF, 0, 0, 16'd1, 1);
        add_vec(16'h8000, 1, 0, 16'hFFFF, 1, 0, 16'd1, 1);
        add_vec(16'h0000, 1, 0, 16'hFFFF, 1, 0, 16'd1, 1);
        add_vec(16'h0000, 1, 0, 16'hFFFF, 1, 0, 16'd1, 1);
        add_vec(16'h0000, 1, 0, 16'h0000, 1, 0, 16'd1, 1);
        add_vec(16'h8000, 1, 0, 16'h0000, 1, 0, 16'd1, 1);
        add_vec(16'h8000, 1, 0, 16'h0000, 1, 0, 16'd1, 1);
        add_vec(16'h8000, 1, 0, 16'hFFFF, 1, WRAP_DOWN_ERR, CNT_MID, 1);
        add_vec(16'h8000, 1, 0, 16'hFFFF, 1, 0, CNT_MID, 1);
        // Clear coincident with an error, then clear alone.
        add_vec(16'h0006, 1, 0, 16'hFFFF, 1, 0, CNT_MID, 1);
        add_vec(16'h0006, 1, 0, 16'hFFFF, 1, 0, CNT_MID, 1);
        add_vec(16'h0006, 1, 1, 16'h0004, 1, 1, 16'd1, 1);
        add_vec(16'h0006, 1, 1, 16'h0004, 1, 0, 16'd0, 0);
        add_vec(16'h0006, 1, 0, 16'h0004, 1, 0, 16'd0, 0);
        // Enable drop, re-acquire at bin 500, then a legal +1.
        add_vec(16'h010E, 0, 0, 16'h0004, 0, 0, 16'd0, 0);
        add_vec(16'h010E, 0, 0, 16'h0004, 0, 0, 16'd0, 0);
        add_vec(16'h010E, 1, 0, 16'h01F4, 0, 0, 16'd0, 0);
        add_vec(16'h010E, 1, 0, 16'h01F4, 1, 0, 16'd0, 0);
        add_vec(16'h010F, 1, 0, 16'h01F4, 1, 0, 16'd0, 0);
        add_vec(16'h010F, 1, 0, 16'h01F4, 1, 0, 16'd0, 0);
        add_vec(16'h010F, 1, 0, 16'h01F5, 1, 0, 16'd0, 0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].gray, vecs[i].en, vecs[i].clr);
            check_output($sformatf("row_%0d", i), vecs[i].bin, vecs[i].valid,
                         vecs[i].err, vecs[i].cnt, vecs[i].sticky);
        end

        // Provoke an error, then reset asynchronously mid-cycle.
        apply_stimulus(16'h0006, 1'b1, 1'b0);
        apply_stimulus(16'h0006, 1'b1, 1'b0);
        apply_stimulus(16'h0006, 1'b1, 1'b0);
        check_output("pre_reset_err", 16'h0004, 1'b1, 1'b1, 16'd1, 1'b1);
        #3;
        rstn    = 1'b0;
        gray_in = 16'h0000;
        #1;
        check_output("async_reset", 16'h0000, 1'b0, 1'b0, 16'd0, 1'b0);
        tick(); tick();
        check_output("held_in_reset", 16'h0000, 1'b0, 1'b0, 16'd0, 1'b0);
        rstn = 1'b1;
        apply_stimulus(16'h0000, 1'b1, 1'b0);
        check_output("post_reset_acq", 16'h0000, 1'b0, 1'b0, 16'd0, 1'b0);
        apply_stimulus(16'h0000, 1'b1, 1'b0);
        check_output("post_reset_track", 16'h0000, 1'b1, 1'b0, 16'd0, 1'b0);
        apply_stimulus(16'h0001, 1'b1, 1'b0);
        apply_stimulus(16'h0001, 1'b1, 1'b0);
        apply_stimulus(16'h0001, 1'b1, 1'b0);
        check_output("post_reset_step", 16'h0001, 1'b1, 1'b0, 16'd0, 1'b0);

        // Narrow counter: 17 errors must stick at 7 rather than wrap.
        for (int i = 0; i < 20; i++) begin
            sat_en   = 1'b1;
            sat_gray = (i % 2 == 0) ? 16'h0000 : 16'h0006;
            tick();
        end
        checks++;
        if (sat_cnt !== 3'd7 || sat_sticky !== 1'b1) begin
            fails++;
            $display("[TB] FAIL saturate: got cnt=%0d sticky=%b, expected cnt=7 sticky=1", sat_cnt, sat_sticky);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
